// File: rtl/tinyrv_bus_pkg.sv
// tinyrv_bus_pkg: phase codes and beat-count helpers shared by the bus sequencer
package tinyrv_bus_pkg;
    typedef enum logic [2:0] {
        PH_PC    = 3'd0,
        PH_INSTR = 3'd1,
        PH_DEC   = 3'd2,
        PH_DADDR = 3'd3,
        PH_DRD   = 3'd4,
        PH_DWR   = 3'd5,
        PH_STEP  = 3'd6,
        PH_IDLE  = 3'd7
    } phase_t;
    function automatic int beats(input int w, input int bw);
        return w / bw;
    endfunction
    function automatic int beat_w(input int a, input int d);
        int m;
        m = a > d ? a : d;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/tinyrv_bus_seq_if.sv
// tinyrv_bus_seq_if: narrow external bus; master = sequencer, slave = memory side
//   bus_in/bus_ready from memory; bus_out/bus_oe/bus_phase/bus_last/bus_we from sequencer
interface tinyrv_bus_seq_if #(
    parameter int BUS_W = 8
);
    logic [BUS_W-1:0] bus_in;
    logic [BUS_W-1:0] bus_out;
    logic             bus_oe;
    logic [2:0]       bus_phase;
    logic             bus_last;
    logic             bus_we;
    logic             bus_ready;
    modport master (
        input  bus_in, bus_ready,
        output bus_out, bus_oe, bus_phase, bus_last, bus_we
    );
    modport slave (
        output bus_in, bus_ready,
        input  bus_out, bus_oe, bus_phase, bus_last, bus_we
    );
endinterface

// File: rtl/tinyrv_beat_ctr.sv
// tinyrv_beat_ctr: beat index within a phase; clears, advances on adv, wraps after last_idx
//   clr: force beat to 0; adv: completed beat; last: beat == last_idx
module tinyrv_beat_ctr
    import tinyrv_bus_pkg::*;
#(
    parameter int MAXB = 2,
    parameter int W    = beat_w(MAXB, 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] last_idx,
    output logic [W-1:0] beat,
    output logic         last
);
    assign last = beat == last_idx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) beat <= '0;
        else if (clr) beat <= '0;
        else if (adv) beat <= last ? '0 : beat + 1'b1;
endmodule

// File: rtl/tinyrv_bus_seq.sv
// tinyrv_bus_seq: multiplexes tinyrv fetch and data access over a narrow ready-gated bus
//   core_*: fetch/data interface to the core, core_step = one-cycle advance pulse
//   bus:    external bus (master side), phase code, last-beat flag and store flag
module tinyrv_bus_seq
    import tinyrv_bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BUS_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [ADDR_W-1:0] core_pc,
    output logic [DATA_W-1:0] core_instr,
    input  logic [ADDR_W-1:0] core_dmem_addr,
    input  logic [DATA_W-1:0] core_dmem_wdata,
    input  logic              core_dmem_we,
    input  logic              core_dmem_re,
    output logic [DATA_W-1:0] core_dmem_rdata,
    output logic              core_step,
    tinyrv_bus_seq_if.master  bus
);
    localparam int ABEATS = beats(ADDR_W, BUS_W);
    localparam int DBEATS = beats(DATA_W, BUS_W);
    localparam int W      = beat_w(ABEATS, DBEATS);
    localparam logic [W-1:0] ALAST = W'(ABEATS - 1);
    localparam logic [W-1:0] DLAST = W'(DBEATS - 1);
    phase_t       phase, nxt;
    logic [W-1:0] beat;
    logic         last, we_q, beat_ph, adv;
    int           off;
    assign beat_ph = phase inside {PH_PC, PH_INSTR, PH_DADDR, PH_DRD, PH_DWR};
    assign adv     = beat_ph & bus.bus_ready;
    assign off     = int'(beat) * BUS_W;
    tinyrv_beat_ctr #(.MAXB(ABEATS > DBEATS ? ABEATS : DBEATS)) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!beat_ph),
        .adv      (adv),
        .last_idx (phase inside {PH_PC, PH_DADDR} ? ALAST : DLAST),
        .beat     (beat),
        .last     (last)
    );
    always_comb begin
        nxt = phase;
        case (phase)
            PH_IDLE:  nxt = ena ? PH_PC : PH_IDLE;
            PH_PC:    if (adv && last) nxt = PH_INSTR;
            PH_INSTR: if (adv && last) nxt = PH_DEC;
            PH_DEC:   nxt = (core_dmem_we || core_dmem_re) ? PH_DADDR : PH_STEP;
            PH_DADDR: if (adv && last) nxt = we_q ? PH_DWR : PH_DRD;
            PH_DRD:   if (adv && last) nxt = PH_STEP;
            PH_DWR:   if (adv && last) nxt = PH_STEP;
            PH_STEP:  nxt = ena ? PH_PC : PH_IDLE;
            default:  nxt = PH_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) phase <= PH_IDLE;
        else phase <= nxt;
    // we_q drops on the edge into STEP so bus_we is already low during STEP
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            we_q            <= 1'b0;
            core_instr      <= '0;
            core_dmem_rdata <= '0;
        end else begin
            if (phase == PH_DEC) we_q <= core_dmem_we;
            else if (nxt == PH_STEP) we_q <= 1'b0;
            if (adv && phase == PH_INSTR) core_instr[off +: BUS_W] <= bus.bus_in;
            if (adv && phase == PH_DRD) core_dmem_rdata[off +: BUS_W] <= bus.bus_in;
        end
    assign bus.bus_phase = phase;
    assign bus.bus_oe    = phase inside {PH_PC, PH_DADDR, PH_DWR};
    assign bus.bus_out   = phase == PH_PC    ? core_pc[off +: BUS_W] :
                           phase == PH_DADDR ? core_dmem_addr[off +: BUS_W] :
                           phase == PH_DWR   ? core_dmem_wdata[off +: BUS_W] : '0;
    assign bus.bus_last  = beat_ph & last;
    assign bus.bus_we    = we_q;
    assign core_step     = phase == PH_STEP;
endmodule

// File: tb/tb_tinyrv_bus_seq.sv
// tb_tinyrv_bus_seq: directed scenarios for the tinyrv bus sequencer at default widths
module tb_tinyrv_bus_seq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        ena = 0;
    logic [15:0] core_pc = 0;
    logic [15:0] core_instr;
    logic [15:0] core_dmem_addr = 0;
    logic [15:0] core_dmem_wdata = 0;
    logic        core_dmem_we = 0;
    logic        core_dmem_re = 0;
    logic [15:0] core_dmem_rdata;
    logic        core_step;
    int          n_cmp = 0;
    int          n_bad = 0;

    tinyrv_bus_seq_if #(.BUS_W(8)) bif();

    tinyrv_bus_seq #(.ADDR_W(16), .DATA_W(16), .BUS_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .core_pc         (core_pc),
        .core_instr      (core_instr),
        .core_dmem_addr  (core_dmem_addr),
        .core_dmem_wdata (core_dmem_wdata),
        .core_dmem_we    (core_dmem_we),
        .core_dmem_re    (core_dmem_re),
        .core_dmem_rdata (core_dmem_rdata),
        .core_step       (core_step),
        .bus             (bif)
    );

    always #5 clk = ~clk;

    // Reset, release, raise ena; the next negedge is cycle 0 (PC beat 0).
    task automatic start();
        ena = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        ena = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        ena = 0;
        bif.bus_ready = 1;
        bif.bus_in = 8'h5A;
        @(negedge clk);
        n_cmp++;
        if (int'(bif.bus_phase) !== 7) begin n_bad++; $display("FAIL reset_phase got %0d exp 7", bif.bus_phase); end
        n_cmp++;
        if ({bif.bus_out, bif.bus_oe, bif.bus_we, bif.bus_last, core_step} !== 12'h0) begin
            n_bad++; $display("FAIL reset_outs out=%h oe=%b we=%b last=%b step=%b exp all 0", bif.bus_out, bif.bus_oe, bif.bus_we, bif.bus_last, core_step);
        end
        n_cmp++;
        if ({core_instr, core_dmem_rdata} !== 32'h0) begin n_bad++; $display("FAIL reset_regs instr=%h rdata=%h exp 0", core_instr, core_dmem_rdata); end
        rst_n = 1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (int'(bif.bus_phase) !== 7 || core_step !== 1'b0) begin n_bad++; $display("FAIL idle_hold phase=%0d step=%b exp 7/0", bif.bus_phase, core_step); end
    endtask

    task automatic test_fetch();
        int ph[6] = '{0, 0, 1, 1, 2, 6};
        int bo[6] = '{'h34, 'h12, 0, 0, 0, 0};
        int oe[6] = '{1, 1, 0, 0, 0, 0};
        int ls[6] = '{0, 1, 0, 1, 0, 0};
        int bi[6] = '{0, 0, 'hCD, 'hAB, 0, 0};
        core_pc = 16'h1234;
        core_dmem_we = 0;
        core_dmem_re = 0;
        bif.bus_ready = 1;
        start();
        for (int c = 0; c < 18; c++) begin
            int m;
            m = c % 6;
            @(negedge clk);
            bif.bus_in = 8'(bi[m]);
            n_cmp++;
            if (int'(bif.bus_phase) != ph[m]) begin n_bad++; $display("FAIL fetch_phase c%0d got %0d exp %0d", c, bif.bus_phase, ph[m]); end
            n_cmp++;
            if (int'(bif.bus_out) != bo[m] || int'(bif.bus_oe) != oe[m]) begin
                n_bad++; $display("FAIL fetch_bus c%0d out=%h oe=%b exp %h/%0d", c, bif.bus_out, bif.bus_oe, bo[m], oe[m]);
            end
            n_cmp++;
            if (int'(bif.bus_last) != ls[m]) begin n_bad++; $display("FAIL fetch_last c%0d got %b exp %0d", c, bif.bus_last, ls[m]); end
            n_cmp++;
            if (core_step !== (m == 5)) begin n_bad++; $display("FAIL fetch_step c%0d got %b exp %b", c, core_step, m == 5); end
            if (c >= 4) begin
                n_cmp++;
                if (core_instr !== 16'hABCD) begin n_bad++; $display("FAIL fetch_instr c%0d got %h exp abcd", c, core_instr); end
            end
        end
    endtask

    task automatic test_store();
        int ph[10] = '{0, 0, 1, 1, 2, 3, 3, 5, 5, 6};
        int bo[10] = '{'h34, 'h12, 0, 0, 0, 'h01, 'h80, 'hEF, 'hBE, 0};
        int oe[10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
        int we[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        int ls[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
        core_pc = 16'h1234;
        core_dmem_addr = 16'h8001;
        core_dmem_wdata = 16'hBEEF;
        core_dmem_we = 1;
        core_dmem_re = 0;
        bif.bus_in = 8'h00;
        start();
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 10) begin
                n_cmp++;
                if (int'(bif.bus_phase) != 0) begin n_bad++; $display("FAIL store_next got %0d exp 0", bif.bus_phase); end
            end else begin
                n_cmp++;
                if (int'(bif.bus_phase) != ph[c]) begin n_bad++; $display("FAIL store_phase c%0d got %0d exp %0d", c, bif.bus_phase, ph[c]); end
                n_cmp++;
                if (int'(bif.bus_out) != bo[c] || int'(bif.bus_oe) != oe[c]) begin
                    n_bad++; $display("FAIL store_bus c%0d out=%h oe=%b exp %h/%0d", c, bif.bus_out, bif.bus_oe, bo[c], oe[c]);
                end
                n_cmp++;
                if (int'(bif.bus_we) != we[c] || int'(bif.bus_last) != ls[c]) begin
                    n_bad++; $display("FAIL store_we_last c%0d we=%b last=%b exp %0d/%0d", c, bif.bus_we, bif.bus_last, we[c], ls[c]);
                end
                n_cmp++;
                if (core_step !== (c == 9)) begin n_bad++; $display("FAIL store_step c%0d got %b exp %b", c, core_step, c == 9); end
            end
        end
    endtask

    // Leaves the sequencer in STEP with ena=1; test_both continues from here.
    task automatic test_load();
        int ph[10] = '{0, 0, 1, 1, 2, 3, 3, 4, 4, 6};
        int bo[10] = '{'h34, 'h12, 0, 0, 0, 'h10, 'h00, 0, 0, 0};
        int oe[10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        int bi[10] = '{0, 0, 'hCD, 'hAB, 0, 0, 0, 'h78, 'h56, 0};
        core_pc = 16'h1234;
        core_dmem_addr = 16'h0010;
        core_dmem_we = 0;
        core_dmem_re = 1;
        start();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bif.bus_in = 8'(bi[c]);
            n_cmp++;
            if (int'(bif.bus_phase) != ph[c]) begin n_bad++; $display("FAIL load_phase c%0d got %0d exp %0d", c, bif.bus_phase, ph[c]); end
            n_cmp++;
            if (int'(bif.bus_out) != bo[c] || int'(bif.bus_oe) != oe[c] || bif.bus_we !== 1'b0) begin
                n_bad++; $display("FAIL load_bus c%0d out=%h oe=%b we=%b exp %h/%0d/0", c, bif.bus_out, bif.bus_oe, bif.bus_we, bo[c], oe[c]);
            end
            n_cmp++;
            if (core_step !== (c == 9)) begin n_bad++; $display("FAIL load_step c%0d got %b exp %b", c, core_step, c == 9); end
        end
        n_cmp++;
        if (core_dmem_rdata !== 16'h5678 || core_instr !== 16'hABCD) begin
            n_bad++; $display("FAIL load_data rdata=%h instr=%h exp 5678/abcd", core_dmem_rdata, core_instr);
        end
    endtask

    task automatic test_both();
        int ph[10] = '{0, 0, 1, 1, 2, 3, 3, 5, 5, 6};
        int bo[10] = '{'h34, 'h12, 0, 0, 0, 'h01, 'h80, 'hEF, 'hBE, 0};
        int we[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        core_dmem_addr = 16'h8001;
        core_dmem_wdata = 16'hBEEF;
        core_dmem_we = 1;
        core_dmem_re = 1;
        bif.bus_in = 8'h99;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (int'(bif.bus_phase) != ph[c]) begin n_bad++; $display("FAIL both_phase c%0d got %0d exp %0d", c, bif.bus_phase, ph[c]); end
            n_cmp++;
            if (int'(bif.bus_out) != bo[c] || int'(bif.bus_we) != we[c]) begin
                n_bad++; $display("FAIL both_bus c%0d out=%h we=%b exp %h/%0d", c, bif.bus_out, bif.bus_we, bo[c], we[c]);
            end
            n_cmp++;
            if (core_dmem_rdata !== 16'h5678) begin n_bad++; $display("FAIL both_rdata c%0d got %h exp 5678", c, core_dmem_rdata); end
            n_cmp++;
            if (core_step !== (c == 9)) begin n_bad++; $display("FAIL both_step c%0d got %b exp %b", c, core_step, c == 9); end
        end
    endtask

    task automatic test_wait();
        int ph[9] = '{0, 0, 1, 1, 1, 1, 1, 2, 6};
        int ls[9] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
        int rd[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        int bi[9] = '{0, 0, 'h11, 'h11, 'h11, 'hCD, 'hAB, 0, 0};
        int ins[9] = '{0, 0, 0, 0, 0, 0, 'h00CD, 'hABCD, 'hABCD};
        core_pc = 16'h1234;
        core_dmem_we = 0;
        core_dmem_re = 0;
        bif.bus_ready = 1;
        start();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bif.bus_ready = rd[c] != 0;
            bif.bus_in = 8'(bi[c]);
            n_cmp++;
            if (int'(bif.bus_phase) != ph[c] || int'(bif.bus_last) != ls[c]) begin
                n_bad++; $display("FAIL wait_phase c%0d phase=%0d last=%b exp %0d/%0d", c, bif.bus_phase, bif.bus_last, ph[c], ls[c]);
            end
            n_cmp++;
            if (int'(core_instr) != ins[c]) begin n_bad++; $display("FAIL wait_instr c%0d got %h exp %h", c, core_instr, ins[c]); end
            n_cmp++;
            if (core_step !== (c == 8) || bif.bus_oe !== (c < 2)) begin
                n_bad++; $display("FAIL wait_step_oe c%0d step=%b oe=%b exp %b/%b", c, core_step, bif.bus_oe, c == 8, c < 2);
            end
        end
        bif.bus_ready = 1;
    endtask

    task automatic test_ena_drop();
        int ph[13] = '{0, 0, 1, 1, 2, 3, 3, 4, 4, 6, 7, 7, 7};
        core_pc = 16'h1234;
        core_dmem_addr = 16'h0010;
        core_dmem_we = 0;
        core_dmem_re = 1;
        bif.bus_in = 8'h00;
        start();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 5) ena = 0;
            n_cmp++;
            if (int'(bif.bus_phase) != ph[c]) begin n_bad++; $display("FAIL ena_phase c%0d got %0d exp %0d", c, bif.bus_phase, ph[c]); end
            n_cmp++;
            if (core_step !== (c == 9)) begin n_bad++; $display("FAIL ena_step c%0d got %b exp %b", c, core_step, c == 9); end
        end
    endtask

    task automatic test_reset_mid();
        core_pc = 16'h1234;
        core_dmem_addr = 16'h8001;
        core_dmem_wdata = 16'hBEEF;
        core_dmem_we = 1;
        core_dmem_re = 0;
        bif.bus_in = 8'h00;
        start();
        for (int c = 0; c < 8; c++) @(negedge clk);
        n_cmp++;
        if (int'(bif.bus_phase) != 5 || bif.bus_oe !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre phase=%0d oe=%b exp 5/1", bif.bus_phase, bif.bus_oe); end
        rst_n = 0;
        ena = 0;
        #1;
        n_cmp++;
        if (int'(bif.bus_phase) != 7) begin n_bad++; $display("FAIL rstmid_phase got %0d exp 7", bif.bus_phase); end
        n_cmp++;
        if ({bif.bus_out, bif.bus_oe, bif.bus_we, bif.bus_last, core_step} !== 12'h0 || {core_instr, core_dmem_rdata} !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_outs out=%h oe=%b we=%b last=%b step=%b instr=%h rdata=%h exp all 0",
                              bif.bus_out, bif.bus_oe, bif.bus_we, bif.bus_last, core_step, core_instr, core_dmem_rdata);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1;
            n_cmp++;
            if (core_step !== 1'b0 || int'(bif.bus_phase) != 7) begin
                n_bad++; $display("FAIL rstmid_after c%0d step=%b phase=%0d exp 0/7", c, core_step, bif.bus_phase);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_both();
        test_wait();
        test_ena_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tinyrv_bus_seq.md
Name: tinyrv_bus_seq

Overview:
Parametrised external-bus sequencer for the tinyrv core, running entirely on one clock edge. It time-multiplexes instruction fetch and data access over a narrow bidirectional bus. It supports configurable address, data and bus widths, an external ready/wait handshake, and skips the data phases when the instruction makes no memory access. Each completed instruction produces a single-cycle core_step pulse, which the core uses as its clock enable.

Parameters:
- ADDR_W, 16, core address width; must be a multiple of BUS_W.
- DATA_W, 16, instruction and data word width; must be a multiple of BUS_W.
- BUS_W, 8, external bus width.
- Derived: ABEATS = ADDR_W/BUS_W, DBEATS = DATA_W/BUS_W.

Ports:
- clk  in  1  system clock, rising edge only.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  run enable.
- core_pc  in  ADDR_W  fetch address from the core.
- core_instr  out  DATA_W  registered fetched instruction.
- core_dmem_addr  in  ADDR_W  data address from the core.
- core_dmem_wdata  in  DATA_W  store data from the core.
- core_dmem_we  in  1  store request.
- core_dmem_re  in  1  load request.
- core_dmem_rdata  out  DATA_W  registered load data.
- core_step  out  1  one-cycle pulse; the core advances one instruction.
- bus_in  in  BUS_W  bus read data.
- bus_out  out  BUS_W  bus drive data.
- bus_oe  out  1  bus output enable.
- bus_phase  out  3  current phase code.
- bus_last  out  1  current beat is the last beat of its phase.
- bus_we  out  1  current access is a store; valid from DADDR through DWR.
- bus_ready  in  1  external ready; a beat completes only on a clk edge with bus_ready=1.

Behaviour:
- Phase codes: PC=0, INSTR=1, DEC=2, DADDR=3, DRD=4, DWR=5, STEP=6, IDLE=7.
- Reset: phase=IDLE, beat counter=0. All of the following are 0: bus_out, bus_oe, bus_we, bus_last, core_step, core_instr, core_dmem_rdata.
- Beat order is little-endian: beat k carries bits [k*BUS_W +: BUS_W].
- A beat advances only when bus_ready=1. While bus_ready=0, the phase, beat, bus_out, bus_oe and bus_we hold and nothing is captured.
- IDLE: bus_oe=0. Move to PC on the first clk with ena=1.
- PC: ABEATS beats; bus_oe=1; bus_out = core_pc beat.
- INSTR: DBEATS beats; bus_oe=0; each completing beat writes bus_in into the matching slice of core_instr.
- DEC: exactly 1 cycle regardless of bus_ready; bus_oe=0.
  - Samples core_dmem_we and core_dmem_re and latches bus_we = core_dmem_we.
  - we=1 goes to DADDR. If we and re are both 1, the access is a store and no read occurs.
  - re=1 alone goes to DADDR.
  - Neither set goes to STEP.
- DADDR: ABEATS beats; bus_oe=1; bus_out = core_dmem_addr beat. Then DWR if bus_we=1, else DRD.
- DRD: DBEATS beats; bus_oe=0; each completing beat writes bus_in into the matching slice of core_dmem_rdata.
- DWR: DBEATS beats; bus_oe=1; bus_out = core_dmem_wdata beat.
- STEP: exactly 1 cycle.
  - core_step=1, bus_oe=0, bus_we cleared.
  - Next phase is PC if ena=1, else IDLE.
- bus_out is 0 whenever bus_oe=0.
- bus_last=1 on the final beat of PC, INSTR, DADDR, DRD and DWR; 0 in DEC, STEP and IDLE.
- Core inputs are sampled only in the phases above. The core must hold them stable between core_step pulses.
- Latency with bus_ready=1 throughout, defaults (ABEATS=DBEATS=2):
  - no-access instruction: 6 cycles;
  - load or store: 10 cycles.
  - core_step pulses are therefore spaced 6 or 10 cycles apart.
- ena=0 mid-instruction: the instruction completes through STEP, then the block enters IDLE. No partial abort.
- Asynchronous reset mid-beat: all state returns to reset values immediately; no core_step is issued.
- core_instr and core_dmem_rdata retain their values outside their capture phases.

Decomposition:
- Package tinyrv_bus_pkg holds:
  - the phase enum and codes above;
  - the ABEATS/DBEATS derivation function;
  - the beat-index width function (clog2 of max(ABEATS, DBEATS), minimum 1).
- One sub-module, tinyrv_beat_ctr: a beat counter with load, ready-gated advance and a last flag, parametrised by the maximum beat count.

Test Plan:
- Reset, then ena=1, core_pc=0x1234, no access, bus_ready=1:
  - bus_out is 0x34 then 0x12 with bus_oe=1;
  - bus_in 0xCD then 0xAB gives core_instr=0xABCD;
  - core_step pulses 6 cycles after leaving IDLE, and every 6 cycles thereafter.
- Store with addr=0x8001, wdata=0xBEEF:
  - DADDR drives 0x01, 0x80;
  - DWR drives 0xEF, 0xBE with bus_oe=1 and bus_we=1;
  - core_step comes 10 cycles after entering PC.
- Load with addr=0x0010, bus_in 0x78 then 0x56 in DRD:
  - core_dmem_rdata=0x5678, bus_oe=0 during DRD, bus_we=0.
- bus_ready=0 for 3 cycles on INSTR beat 0:
  - phase and outputs hold and nothing is captured;
  - core_step is delayed by exactly 3 cycles.
- we=1 and re=1 together: DWR is taken, no DRD occurs, and core_dmem_rdata is unchanged.
- ena dropped during DADDR: the access completes, core_step pulses once, and phase goes to 7 (IDLE) and stays there.
- rst_n asserted during DWR: outputs immediately take their reset values and no core_step pulse follows.
